// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes the immediate of each accepted instruction
// into a small in-order FIFO, with sideband tag, illegal-select flag and a saturating counter.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst,
    input  logic [4:0]       imm_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [XLEN-1:0]  imm_mem_q [DEPTH];
    logic [TAG_W-1:0] tag_mem_q [DEPTH];
    logic             ill_mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;
    logic             push, pop;

    // Opcode bits never contribute to any immediate format.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // NOTE: every variable driven in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        case (imm_sel)
            5'd0: dec_imm = '0;
            5'd1: dec_imm = XLEN'($signed({inst[31:25], inst[11:7]}));
            5'd2: dec_imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            5'd3: dec_imm = XLEN'($signed({inst[31:12], 12'b0}));
            5'd4: dec_imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            5'd5: dec_imm = XLEN'($signed(inst[31:20]));
            5'd6: begin
                if (XLEN == 32) dec_imm = XLEN'(inst[24:20]);
                else            dec_imm = XLEN'(inst[25:20]);
            end
            5'd7: dec_imm = XLEN'(inst[19:15]);
            default: dec_ill = 1'b1;
        endcase
    end

    assign in_ready  = (count_q < FULL_LVL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        cnt_d   = cnt_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + LVL_W'(1);
                2'b01:   count_d = count_q - LVL_W'(1);
                default: count_d = count_q;
            endcase
            if (push && dec_ill && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            cnt_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: entry storage is not reset; the head outputs are gated by out_valid, so stale data never leaks.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            imm_mem_q[tail_q] <= dec_imm;
            tag_mem_q[tail_q] <= in_tag;
            ill_mem_q[tail_q] <= dec_ill;
        end
    end

    assign imm         = out_valid ? imm_mem_q[head_q] : '0;
    assign out_tag     = out_valid ? tag_mem_q[head_q] : '0;
    assign out_illegal = out_valid && ill_mem_q[head_q];
    assign illegal_cnt = cnt_q;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Registered, parametrised successor to the combinational immediate generator in the decode stage. Each accepted instruction gets its immediate decoded per `imm_sel` at configurable width (RV32/RV64), stored in a small output FIFO, and handed on over a valid/ready handshake. Also supports a sideband tag, CSR zimm decoding, illegal-select flagging, flush, and a saturating illegal-select counter. Sits between fetch/decode and the execute-stage operand muxes, so the generator can be decoupled from execute stalls.

## Interface
- `XLEN`, 32, immediate output width; legal values 32 or 64 only.
- `DEPTH`, 2, output FIFO entries; power of two, minimum 2.
- `TAG_W`, 8, width of the sideband tag (e.g. ROB/PC index) carried with each entry.
- `CNT_W`, 16, width of the illegal-select counter.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  drops all queued entries; synchronous.
- `in_valid`  in  1  upstream has an instruction.
- `in_ready`  out  1  block can accept; high when count < DEPTH.
- `inst`  in  32  instruction word.
- `imm_sel`  in  5  immediate format select.
- `in_tag`  in  TAG_W  sideband, passed through unmodified.
- `out_valid`  out  1  FIFO head valid.
- `out_ready`  in  1  downstream consumes head.
- `imm`  out  XLEN  immediate at FIFO head.
- `out_tag`  out  TAG_W  tag at FIFO head.
- `out_illegal`  out  1  head entry had an unsupported `imm_sel`.
- `illegal_cnt`  out  CNT_W  saturating count of accepted illegal selects.

## Operation
- Push when `in_valid && in_ready`; pop when `out_valid && out_ready`.
- Decode is combinational on the inputs and registered into the FIFO on push. sext/zext below are to XLEN.
- `imm_sel` encoding:
  - 0 R: zero.
  - 1 S: sext({inst[31:25],inst[11:7]}).
  - 2 B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - 3 U: sext({inst[31:12],12'b0}); identical to zext for XLEN=32.
  - 4 J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - 5 I: sext(inst[31:20]).
  - 6 I* (shamt): zext(inst[24:20]) if XLEN=32, zext(inst[25:20]) if XLEN=64.
  - 7 CSR zimm (new): zext(inst[19:15]).
  - 8–31: imm=0, illegal=1.
- FIFO is in-order with head/tail pointers wrapping modulo DEPTH and a count of width clog2(DEPTH)+1.
- `illegal_cnt` increments on each pushed illegal entry, saturates at 2^CNT_W-1, and is unaffected by flush.

## Timing
- Latency 1 cycle: an entry pushed at edge N shows `out_valid`=1 with its data after edge N. No same-cycle bypass.
- `in_ready` depends only on registered count; there is no combinational path from `out_ready` to `in_ready`.
- Full (count=DEPTH): `in_ready`=0. A pop at edge N raises `in_ready` after edge N.
- Empty: `out_valid`=0; `out_ready` is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance, order preserved.
- `flush` at edge N:
  - count, head and tail all go to 0.
  - Any push or pop requested that cycle is discarded; the illegal counter does not increment for a discarded push.
  - `out_valid`=0 after edge N.
- `rst` has priority over `flush`. After any reset edge, including mid-operation:
  - `out_valid`=0, `in_ready`=1, `imm`=0, `out_tag`=0, `out_illegal`=0, `illegal_cnt`=0.
  - Pointers and count are 0.
- Outputs hold stable while `out_valid && !out_ready`.

## Test plan
- Per-format decode, XLEN=32, one push each with `out_ready`=1; each result is required one cycle after push:
  - I 0xFCE00093 -> 0xFFFFFFCE (-50).
  - S 0x00112A23 -> 20.
  - B 0x00008463 -> 8.
  - U 0x123450B7 -> 0x12345000.
  - J 0x010000EF -> 16.
  - I* 0x00411093 -> 4.
  - sel 7 with inst[19:15]=5'd31 -> 31.
  - R -> 0.
- XLEN=64: U 0x800000B7 -> 0xFFFFFFFF80000000; I* slli shamt 33 (inst[25:20]=6'd33) -> 33.
- Backpressure, DEPTH=2, `out_ready`=0, push tags 1,2,3:
  - `in_ready`=0 after the second push; tag 3 is held upstream.
  - Then `out_ready`=1: tags pop 1,2,3 in order, with head data stable while stalled.
- Concurrent push/pop at count=1 for 10 cycles -> count stays 1 and the tag sequence is preserved with no loss or duplicate.
- Flush with 2 entries queued while `in_valid`=1 -> `out_valid`=0 next cycle, the flushed-cycle input is not enqueued, and `illegal_cnt` is unchanged.
- `imm_sel`=9 pushed 3 times -> `out_illegal`=1 and imm=0 for each; `illegal_cnt`=3.
- With CNT_W=2, 5 illegal pushes -> `illegal_cnt` saturates at 3.
- `rst` mid-stream with a full FIFO -> all outputs at reset values next cycle.
